// File: rtl/victory_tracker.sv
// victory_tracker: round-win detection, score keeping, win hold and newGame pulse for tug-of-war.
// Define VICTORY_TRACKER_HEX_EN to drive registered 7-segment score decodes on hexL/hexR.
module victory_tracker #(
  parameter int MAX_SCORE   = 7,
  parameter int HOLD_CYCLES = 4,
  parameter int SCORE_W     = 3
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               L,
  input  logic               R,
  input  logic               edgeL,
  input  logic               edgeR,
  output logic               newGame,
  output logic               winL,
  output logic               winR,
  output logic               matchOver,
  output logic [SCORE_W-1:0] scoreL,
  output logic [SCORE_W-1:0] scoreR,
  output logic [6:0]         hexL,
  output logic [6:0]         hexR
);
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [1:0] {PLAY, HOLD, MATCH_OVER} state_t;
  state_t state, state_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [SCORE_W-1:0] score_l_n, score_r_n, score_l_inc, score_r_inc;
  logic new_game_n, win_l_n, win_r_n, match_n;
  logic left_win, right_win;
  // Detection is blanked while newGame is high: the playfield is still re-centring.
  assign left_win    = edgeL & L & ~R & ~newGame;
  assign right_win   = edgeR & R & ~L & ~newGame;
  assign score_l_inc = scoreL + SCORE_W'(1);
  assign score_r_inc = scoreR + SCORE_W'(1);
  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    score_l_n  = scoreL;
    score_r_n  = scoreR;
    new_game_n = 1'b0;
    win_l_n    = winL;
    win_r_n    = winR;
    match_n    = matchOver;
    case (state)
      PLAY: begin
        if (left_win) begin
          score_l_n  = score_l_inc;
          win_l_n    = 1'b1;
          match_n    = score_l_inc == SCORE_W'(MAX_SCORE);
          state_n    = match_n ? MATCH_OVER : HOLD;
          hold_cnt_n = HW'(HOLD_CYCLES - 1);
        end else if (right_win) begin
          score_r_n  = score_r_inc;
          win_r_n    = 1'b1;
          match_n    = score_r_inc == SCORE_W'(MAX_SCORE);
          state_n    = match_n ? MATCH_OVER : HOLD;
          hold_cnt_n = HW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        hold_cnt_n = hold_cnt == '0 ? hold_cnt : hold_cnt - HW'(1);
        state_n    = hold_cnt == '0 ? PLAY : HOLD;
        new_game_n = hold_cnt == '0;
        win_l_n    = hold_cnt == '0 ? 1'b0 : winL;
        win_r_n    = hold_cnt == '0 ? 1'b0 : winR;
      end
      MATCH_OVER: state_n = MATCH_OVER;
      default: state_n = PLAY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!Reset) begin
      state     <= PLAY;
      hold_cnt  <= '0;
      scoreL    <= '0;
      scoreR    <= '0;
      newGame   <= 1'b0;
      winL      <= 1'b0;
      winR      <= 1'b0;
      matchOver <= 1'b0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_cnt_n;
      scoreL    <= score_l_n;
      scoreR    <= score_r_n;
      newGame   <= new_game_n;
      winL      <= win_l_n;
      winR      <= win_r_n;
      matchOver <= match_n;
    end
  end
`ifdef VICTORY_TRACKER_HEX_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction
  always_ff @(posedge clk) begin
    if (!Reset) begin
      hexL <= 7'b1000000;
      hexR <= 7'b1000000;
    end else begin
      hexL <= seg7(4'(scoreL));
      hexR <= seg7(4'(scoreR));
    end
  end
`else
  assign hexL = 7'b1111111;
  assign hexR = 7'b1111111;
`endif
endmodule

// File: tb/tb_victory_tracker.sv
// tb_victory_tracker: scoreboard bench; each cycle's expected outputs are queued with the stimulus.
module tb_victory_tracker;
  logic clk = 1'b0;
  logic rst_n, l, r, el, er;
  logic new_game, win_l, win_r, match_over;
  logic [2:0] score_l, score_r;
  logic [6:0] hex_l, hex_r;
  logic [23:0] obs, e;
  logic [23:0] exp_q[$];
  int vectors = 0, errors = 0;
  int esl, esr, psl, psr;
  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  always #5 clk = ~clk;
  victory_tracker dut (
    .clk(clk), .Reset(rst_n), .L(l), .R(r), .edgeL(el), .edgeR(er),
    .newGame(new_game), .winL(win_l), .winR(win_r), .matchOver(match_over),
    .scoreL(score_l), .scoreR(score_r), .hexL(hex_l), .hexR(hex_r)
  );
  assign obs = {new_game, win_l, win_r, match_over, score_l, score_r, hex_l, hex_r};
  // Expected outputs from the bench's expected scores; the displays lag the scores by one cycle.
  function automatic logic [23:0] mk(input logic ng, input logic wl, input logic wr, input logic mo);
    logic [6:0] hl, hr;
`ifdef VICTORY_TRACKER_HEX_EN
    hl = seg_tab[psl];
    hr = seg_tab[psr];
`else
    hl = 7'b1111111;
    hr = 7'b1111111;
`endif
    psl = esl;
    psr = esr;
    return {ng, wl, wr, mo, 3'(esl), 3'(esr), hl, hr};
  endfunction
  task automatic drive(input logic rs, input logic il, input logic ir, input logic iel, input logic ier);
    rst_n = rs; l = il; r = ir; el = iel; er = ier;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 2) begin esl = 0; esr = 0; psl = 0; psr = 0; end
      exp_q.push_back(mk(0, 0, 0, 0));
      drive(i >= 2, 0, 0, 0, 0);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin errors++; $display("FAIL reset cyc %0d got %h want %h", i, obs, e); end
    end
  endtask
  // One full round won by one side; with noise, both presses and edges toggle through the hold
  // and a valid-looking win is offered while newGame is high.
  task automatic win_round(input string name, input bit left, input bit noise);
    for (int i = 0; i < 7; i++) begin
      logic il, ir, iel, ier;
      il = 0; ir = 0; iel = 0; ier = 0;
      if (i == 0) begin il = left; ir = !left; iel = left; ier = !left; end
      else if (noise && i < 6) begin il = i[0]; ir = !i[0]; iel = 1; ier = 1; end
      if (i == 0) begin if (left) esl++; else esr++; end
      exp_q.push_back(mk(i == 4, left && i < 4, !left && i < 4, 0));
      drive(1, il, ir, iel, ier);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin errors++; $display("FAIL %s cyc %0d got %h want %h", name, i, obs, e); end
    end
  endtask
  task automatic test_left_win();
    win_round("left_win", 1, 0);
  endtask
  task automatic test_hold_ignore();
    win_round("hold_ignore", 1, 1);
  endtask
  task automatic test_tie();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(0, 0, 0, 0));
      drive(1, 1, 1, i == 1, 1);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin errors++; $display("FAIL tie cyc %0d got %h want %h", i, obs, e); end
    end
    win_round("right_win", 0, 0);
  endtask
  task automatic test_match();
    esl = 0; esr = 0; psl = 0; psr = 0;
    exp_q.push_back(mk(0, 0, 0, 0));
    drive(0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    vectors++;
    if (obs !== e) begin errors++; $display("FAIL match_reset got %h want %h", obs, e); end
    for (int w = 0; w < 6; w++) win_round("match_round", 1, 0);
    for (int i = 0; i < 21; i++) begin
      if (i == 0) esl++;
      exp_q.push_back(mk(0, 1, 0, 1));
      if (i == 0) drive(1, 1, 0, 1, 0);
      else drive(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin errors++; $display("FAIL match_over cyc %0d got %h want %h", i, obs, e); end
    end
  endtask
  task automatic test_reset_mid_hold();
    for (int i = 0; i < 12; i++) begin
      if (i == 0) esl++;
      if (i == 3) begin esl = 0; esr = 0; psl = 0; psr = 0; end
      exp_q.push_back(mk(0, i < 3, 0, 0));
      drive(i != 3, i == 0, 0, i == 0, 0);
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin errors++; $display("FAIL reset_mid_hold cyc %0d got %h want %h", i, obs, e); end
    end
  endtask
  initial begin
    rst_n = 0; l = 0; r = 0; el = 0; er = 0;
    esl = 0; esr = 0; psl = 0; psr = 0;
    #2;
    test_reset();
    test_left_win();
    test_hold_ignore();
    test_tie();
    test_match();
    test_reset();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
